// File: rtl/lsq_index_queue.sv
// In-order queue of ROB indices for memory ops: accepts up to four packed {valid,idx} slots per
// cycle, compacts them in slot order, and presents the oldest index to the LSQ.
// Optional same-cycle bypass when empty: define LSQ_IDXQ_BYPASS_EN.
module lsq_index_queue #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*(IDX_W+1)-1:0]   idx_in,
  output logic                     idx_stall,
  input  logic                     flush,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [IDX_W-1:0]         deq_idx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int SW = IDX_W + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic [3:0]       slot_v;
  logic [IDX_W-1:0] slot_idx [4];
  logic [2:0]       slot_pos [4];
  logic [2:0]       n_valid;
  logic [CW-1:0]    free;

  logic             accept;
  logic             pop;
  logic             byp_valid;
  logic [IDX_W-1:0] byp_idx;
  logic             skip_first;
  logic [2:0]       n_wr;
  logic [3:0]       slot_we;
  logic [PW-1:0]    slot_addr [4];

  // Unpack slots and give each valid slot its compacted offset (number of valid slots below it).
  always_comb begin
    n_valid = '0;
    for (int k = 0; k < 4; k++) begin
      slot_v[k]   = idx_in[k*SW + IDX_W];
      slot_idx[k] = idx_in[k*SW +: IDX_W];
      slot_pos[k] = n_valid;
      n_valid     = n_valid + {2'b00, slot_v[k]};
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Space is judged on the registered count only; a pop in the same cycle gives no credit.
  assign free      = CW'(DEPTH) - count;
  assign idx_stall = (CW'(n_valid) > free) & ~flush;
  assign accept    = ~idx_stall & ~flush;

`ifdef LSQ_IDXQ_BYPASS_EN
  logic [IDX_W-1:0] first_idx;

  always_comb begin
    first_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (slot_v[k]) first_idx = slot_idx[k];
    end
  end

  assign byp_valid = empty & (n_valid != 3'd0) & ~flush;
  assign byp_idx   = first_idx;
`else
  assign byp_valid = 1'b0;
  assign byp_idx   = '0;
`endif

  // Handshake: deq_valid/deq_idx are stable-per-cycle offers; an entry is consumed on any cycle
  // where deq_valid & deq_ready are both high (and flush is low). deq_idx is meaningless when
  // deq_valid is low; it is forced to zero then so reset shows a clean value.
  assign deq_valid  = ~empty | byp_valid;
  assign deq_idx    = byp_valid ? byp_idx : (empty ? '0 : mem[rd_ptr]);
  assign pop        = ~empty & deq_ready & ~flush;
  assign skip_first = byp_valid & deq_ready;
  assign n_wr       = n_valid - {2'b00, skip_first};

  // A bypassed-and-consumed first slot is not stored; the rest shift down by one entry.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot_we[k]   = accept & slot_v[k] & ~(skip_first & (slot_pos[k] == 3'd0));
      slot_addr[k] = wr_ptr + PW'(slot_pos[k]) - PW'(skip_first);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(n_wr);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + (accept ? CW'(n_wr) : CW'(0)) - CW'(pop);
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (slot_we[k]) mem[slot_addr[k]] <= slot_idx[k];
    end
  end

endmodule
